mem_access_unit: RTL and testbench

//  Load/store sequencer between the pipeline memory stage and the word-wide data RAM.
//  The RAM has a 1-cycle registered read and a word-only write.

---
 rtl/mem_access_unit_pkg.sv | 22 ++
 rtl/mem_access_unit_byte_lane.sv | 42 ++++
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store sequencer: data width, bytes per word,
// FSM state encoding and the word-alignment helper.
package mem_access_unit_pkg;

  localparam int FULLW = 32;              // data and byte-address width
  localparam int WORD  = 4;               // bytes per word
  localparam int LANEW = $clog2(WORD);    // byte-lane select width

  typedef enum logic [2:0] {
    MAU_IDLE  = 3'd0,
    MAU_READ  = 3'd1,
    MAU_RDATA = 3'd2,
    MAU_WRITE = 3'd3,
    MAU_RESP  = 3'd4
  } mau_state_e;

  // A word access whose low address bits are not zero is misaligned.
  function automatic logic is_misaligned(input logic byte_acc, input logic [LANEW-1:0] lane);
    return ~byte_acc & (lane != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// Combinational byte-lane helper: extracts one little-endian byte from a word
// (zero- or sign-filled) and merges a byte into a word. Used both by the load
// return path and by the read-modify-write of byte stores.
module mem_access_unit_byte_lane
  import mem_access_unit_pkg::*;
(
  input  logic [FULLW-1:0] word,
  input  logic [LANEW-1:0] lane,
  input  logic             sext,
  input  logic [7:0]       lane_byte,
  output logic [FULLW-1:0] extracted,
  output logic [FULLW-1:0] merged
);

  logic [7:0] sel;

  // Pick the addressed byte and widen it to a full word.
  always_comb begin
    sel = 8'h00;
    case (lane)
      2'd0:    sel = word[7:0];
      2'd1:    sel = word[15:8];
      2'd2:    sel = word[23:16];
      2'd3:    sel = word[31:24];
      default: sel = 8'h00;
    endcase
    extracted = {{(FULLW-8){sext & sel[7]}}, sel};
  end

  // Replace the addressed byte, keeping the other three lanes intact.
  always_comb begin
    merged = word;
    case (lane)
      2'd0:    merged[7:0]   = lane_byte;
      2'd1:    merged[15:8]  = lane_byte;
      2'd2:    merged[23:16] = lane_byte;
      2'd3:    merged[31:24] = lane_byte;
      default: merged        = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the pipeline memory stage and a word-wide RAM
// with 1-cycle registered read. Handles word and byte loads/stores; byte
// stores are done as read-modify-write.
// Optional feature macro: MAU_ALIGN_CHECK_EN -- when defined, misaligned word
// accesses are answered immediately with rsp_fault=1 and never touch the RAM.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int SIGN_EXT_BYTE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic             req_byte,
  input  logic [FULLW-1:0] req_addr,
  input  logic [FULLW-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [FULLW-1:0] rsp_rdata,
  output logic             rsp_fault,
  output logic [FULLW-1:0] ram_ra,
  output logic [FULLW-1:0] ram_wa,
  output logic [FULLW-1:0] ram_wd,
  output logic             ram_we,
  input  logic [FULLW-1:0] ram_out
);

  // Highest byte-address bit that forms the RAM word index.
  localparam int  WHI  = ADDR_WIDTH + 1;
  localparam logic SEXT = (SIGN_EXT_BYTE != 32'sd0);

  mau_state_e       state, next_state;
  logic             accept;
  logic             misalign;
  logic [FULLW-1:0] addr_q, wd_q;
  logic             we_q, byte_q;
  logic [FULLW-1:0] ram_addr;
  logic [FULLW-1:0] lane_extract, lane_merge;

`ifdef MAU_ALIGN_CHECK_EN
  assign misalign = is_misaligned(req_byte, req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // Upper bits pass through untouched; the RAM decodes the word index itself.
  assign ram_addr = {addr_q[FULLW-1:WHI+1], addr_q[WHI:2], addr_q[1:0]};
  assign ram_ra   = ram_addr;
  assign ram_wa   = ram_addr;
  assign ram_wd   = wd_q;

  mem_access_unit_byte_lane u_byte_lane (
    .word      (ram_out),
    .lane      (addr_q[1:0]),
    .sext      (SEXT),
    .lane_byte (wd_q[7:0]),
    .extracted (lane_extract),
    .merged    (lane_merge)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MAU_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, handshake and RAM write strobe; rst blocks both accept and write.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    ram_we     = 1'b0;
    case (state)
      MAU_IDLE: begin
        req_ready = ~rst;
        if (req_valid & ~rst) begin
          accept = 1'b1;
          if (misalign) begin
            next_state = MAU_RESP;
          end else if (req_we & ~req_byte) begin
            next_state = MAU_WRITE;
          end else begin
            next_state = MAU_READ;
          end
        end else begin
          next_state = MAU_IDLE;
        end
      end
      MAU_READ:  next_state = MAU_RDATA;
      MAU_RDATA: begin
        if (we_q) begin
          next_state = MAU_WRITE;
        end else begin
          next_state = MAU_RESP;
        end
      end
      MAU_WRITE: begin
        ram_we     = ~rst;
        next_state = MAU_RESP;
      end
      MAU_RESP:  next_state = MAU_IDLE;
      default:   next_state = MAU_IDLE;
    endcase
  end

  // Request latches, byte-store merge and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= 32'h0;
      wd_q      <= 32'h0;
      we_q      <= 1'b0;
      byte_q    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      rsp_valid <= (next_state == MAU_RESP);
      if (accept) begin
        addr_q    <= req_addr;
        wd_q      <= req_wdata;
        we_q      <= req_we;
        byte_q    <= req_byte;
        rsp_rdata <= 32'h0;
      end else if (state == MAU_RDATA) begin
        if (we_q) begin
          wd_q <= lane_merge;
        end else begin
          rsp_rdata <= byte_q ? lane_extract : ram_out;
        end
      end
    end
  end

`ifdef MAU_ALIGN_CHECK_EN
  // Fault flag is captured at accept and held through the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_fault <= 1'b0;
    end else if (accept) begin
      rsp_fault <= misalign;
    end
  end
`else
  assign rsp_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (zero- and sign-extending byte
// loads) share one request stream, each with its own RAM model. Directed table
// vectors, a mid-operation reset sequence and randomized traffic are checked
// against a word-array reference model.
module tb_mem_access_unit;

`ifdef MAU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load_en;
  logic        req_valid, req_we, req_byte;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready0, rsp_valid0, rsp_fault0, ram_we0;
  logic [31:0] rsp_rdata0, ram_ra0, ram_wa0, ram_wd0, ram_out0;
  logic        req_ready1, rsp_valid1, rsp_fault1, ram_we1;
  logic [31:0] rsp_rdata1, ram_ra1, ram_wa1, ram_wd1, ram_out1;

  mem_access_unit #(.ADDR_WIDTH(8), .SIGN_EXT_BYTE(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
    .req_we(req_we), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_fault(rsp_fault0),
    .ram_ra(ram_ra0), .ram_wa(ram_wa0), .ram_wd(ram_wd0), .ram_we(ram_we0),
    .ram_out(ram_out0)
  );

  mem_access_unit #(.ADDR_WIDTH(8), .SIGN_EXT_BYTE(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
    .req_we(req_we), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_fault(rsp_fault1),
    .ram_ra(ram_ra1), .ram_wa(ram_wa1), .ram_wd(ram_wd1), .ram_we(ram_we1),
    .ram_out(ram_out1)
  );

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic [31:0] ref_mem [256];

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h44332211;
    return (32'(i) * 32'h01010101) ^ 32'hA5C30F96;
  endfunction

  // RAM models: word-only write, 1-cycle registered read, preload while load_en.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 256; i++) mem0[i] <= init_word(i);
    end else if (ram_we0) begin
      mem0[ram_wa0[9:2]] <= ram_wd0;
    end
    ram_out0 <= mem0[ram_ra0[9:2]];
  end

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 256; i++) mem1[i] <= init_word(i);
    end else if (ram_we1) begin
      mem1[ram_wa1[9:2]] <= ram_wd1;
    end
    ram_out1 <= mem1[ram_ra1[9:2]];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  // Reference model: computes the expected response from the access rules and
  // updates the model memory.
  task automatic model(input logic we, input logic byt, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat, output logic [31:0] rd0,
                       output logic [31:0] rd1, output logic flt, output int nwr,
                       output logic [31:0] wd);
    int idx, sh;
    logic [31:0] old;
    logic [7:0] b;
    idx = int'(addr[9:2]);
    sh  = 8 * int'(addr[1:0]);
    old = ref_mem[idx];
    b   = 8'(old >> sh);
    rd0 = 32'h0; rd1 = 32'h0; flt = 1'b0; nwr = 0; wd = 32'h0;
    if (ALIGN && !byt && addr[1:0] != 2'b00) begin
      lat = 1; flt = 1'b1;
    end else if (we && !byt) begin
      lat = 2; nwr = 1; wd = wdata; ref_mem[idx] = wdata;
    end else if (we) begin
      lat = 4; nwr = 1;
      wd = (old & ~(32'hFF << sh)) | ({24'h0, wdata[7:0]} << sh);
      ref_mem[idx] = wd;
    end else if (byt) begin
      lat = 3; rd0 = {24'h0, b}; rd1 = {{24{b[7]}}, b};
    end else begin
      lat = 3; rd0 = old; rd1 = old;
    end
  endtask

  // Issue one request starting at a negedge with the unit idle; returns at the
  // negedge after the response cycle (the earliest next-accept cycle).
  task automatic do_req(input string name, input logic we, input logic byt,
                        input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                        input logic [31:0] rd0, input logic [31:0] rd1, input logic flt,
                        input int nwr, input logic [31:0] wd);
    int seen0, seen1, wr0, wr1, wrcyc;
    logic [31:0] wdv, rdv0, rdv1;
    logic fv0, fv1;
    seen0 = 0; seen1 = 0; wr0 = 0; wr1 = 0; wrcyc = 0;
    wdv = 32'h0; rdv0 = 32'h0; rdv1 = 32'h0; fv0 = 1'b0; fv1 = 1'b0;
    req_valid = 1'b1; req_we = we; req_byte = byt; req_addr = addr; req_wdata = wdata;
    check({name, " ready_idle"}, 32'(req_ready0), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 8 && seen0 == 0; k++) begin
      check({name, " ready_busy"}, 32'(req_ready0), 32'h0);
      if (ram_we0) begin wr0++; wrcyc = k; wdv = ram_wd0; end
      if (ram_we1) wr1++;
      if (rsp_valid0) begin seen0 = k; rdv0 = rsp_rdata0; fv0 = rsp_fault0; end
      if (rsp_valid1 && seen1 == 0) begin seen1 = k; rdv1 = rsp_rdata1; fv1 = rsp_fault1; end
      @(negedge clk);
    end
    check({name, " latency0"}, 32'(seen0), 32'(lat));
    check({name, " latency1"}, 32'(seen1), 32'(lat));
    check({name, " rdata0"}, rdv0, rd0);
    check({name, " rdata1"}, rdv1, rd1);
    check({name, " fault0"}, 32'(fv0), 32'(flt));
    check({name, " fault1"}, 32'(fv1), 32'(flt));
    check({name, " writes0"}, 32'(wr0), 32'(nwr));
    check({name, " writes1"}, 32'(wr1), 32'(nwr));
    if (nwr > 0) begin
      check({name, " write_cycle"}, 32'(wrcyc), 32'(lat - 1));
      check({name, " write_data"}, wdv, wd);
    end
    check({name, " valid_pulse"}, 32'(rsp_valid0), 32'h0);
    check({name, " ready_after"}, 32'(req_ready0), 32'h1);
  endtask

  typedef struct {
    logic        we;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        flt;
    int          nwr;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int lat, nwr;
    logic [31:0] rd0, rd1, wd, a, w, exp_wd;
    logic flt, we, byt;

    tbl[0]  = '{1'b0, 1'b0, 32'h0,  32'h0,        3, 32'h44332211, 32'h44332211, 1'b0, 0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h2,  32'h0,        3, 32'h00000033, 32'h00000033, 1'b0, 0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 32'h1,  32'hAAAAAAEE, 4, 32'h0,        32'h0,        1'b0, 1, 32'h4433EE11};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,  32'h0,        3, 32'h4433EE11, 32'h4433EE11, 1'b0, 0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h8,  32'hDEADBEEF, 2, 32'h0,        32'h0,        1'b0, 1, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 1'b0, 32'h8,  32'h0,        3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,  32'h44B32211, 2, 32'h0,        32'h0,        1'b0, 1, 32'h44B32211};
    tbl[7]  = '{1'b0, 1'b1, 32'h2,  32'h0,        3, 32'h000000B3, 32'hFFFFFFB3, 1'b0, 0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 32'h3,  32'h0,        3, 32'h00000044, 32'h00000044, 1'b0, 0, 32'h0};
`ifdef MAU_ALIGN_CHECK_EN
    tbl[9]  = '{1'b0, 1'b0, 32'h2,  32'h0,        1, 32'h0,        32'h0,        1'b1, 0, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h6,  32'h11223344, 1, 32'h0,        32'h0,        1'b1, 0, 32'h0};
`else
    tbl[9]  = '{1'b0, 1'b0, 32'h2,  32'h0,        3, 32'h44B32211, 32'h44B32211, 1'b0, 0, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h6,  32'h11223344, 2, 32'h0,        32'h0,        1'b0, 1, 32'h11223344};
`endif
    tbl[11] = '{1'b0, 1'b1, 32'h9,  32'h0,        3, 32'h000000BE, 32'hFFFFFFBE, 1'b0, 0, 32'h0};

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    // Reset and RAM preload.
    rst = 1'b1; load_en = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready",  32'(req_ready0), 32'h0);
    check("reset valid",  32'(rsp_valid0), 32'h0);
    check("reset rdata",  rsp_rdata0,      32'h0);
    check("reset fault",  32'(rsp_fault0), 32'h0);
    check("reset ram_we", 32'(ram_we0),    32'h0);
    check("reset ram_wd", ram_wd0,         32'h0);
    check("reset ram_ra", ram_ra0,         32'h0);
    rst = 1'b0; load_en = 1'b0;
    @(negedge clk);

    // Directed vectors, issued back to back.
    for (int i = 0; i < 12; i++) begin
      model(tbl[i].we, tbl[i].byt, tbl[i].addr, tbl[i].wdata, lat, rd0, rd1, flt, nwr, wd);
      do_req($sformatf("vec%0d", i), tbl[i].we, tbl[i].byt, tbl[i].addr, tbl[i].wdata,
             tbl[i].lat, tbl[i].rd0, tbl[i].rd1, tbl[i].flt, tbl[i].nwr, tbl[i].wd);
    end

    // Byte store aborted by reset during its WRITE cycle.
    exp_wd = (ref_mem[0] & 32'hFFFFFF00) | 32'h00000077;
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_addr = 32'h0; req_wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort ram_we0", 32'(ram_we0), 32'h0);
    check("abort ram_we1", 32'(ram_we1), 32'h0);
    check("abort merged",  ram_wd0,      exp_wd);
    check("abort ready",   32'(req_ready0), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort no_rsp", 32'(rsp_valid0 | rsp_valid1), 32'h0);
      check("abort ready_after", 32'(req_ready0), 32'h1);
    end
    model(1'b0, 1'b0, 32'h0, 32'h0, lat, rd0, rd1, flt, nwr, wd);
    do_req("abort readback", 1'b0, 1'b0, 32'h0, 32'h0, lat, rd0, rd1, flt, nwr, wd);

    // Randomized traffic over a few words so stores and loads collide.
    for (int i = 0; i < 80; i++) begin
      we  = 1'($urandom_range(0, 1));
      byt = 1'($urandom_range(0, 1));
      a   = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a = a | 32'h10000400;
      w   = $urandom;
      model(we, byt, a, w, lat, rd0, rd1, flt, nwr, wd);
      do_req($sformatf("rnd%0d", i), we, byt, a, w, lat, rd0, rd1, flt, nwr, wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
